// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared definitions for FIFO read/write side packers
package fifo_pkg;

    // Slot ordering inside a packed word: first-popped word in the LSBs.
    localparam bit SLOT_LSB_FIRST = 1'b1;

    // Width of a "number of valid slots" field able to hold 0..ratio.
    function automatic int word_cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/pack_accumulator.sv
// rtl/pack_accumulator.sv - slot accumulator collecting FIFO words into a wide word
module pack_accumulator
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_RATIO = 4,
    localparam int CNT_W     = $clog2(PACK_RATIO),
    localparam int ACC_W     = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear,
    output logic [ACC_W-1:0]      acc_data,
    output logic [CNT_W-1:0]      acc_cnt,
    output logic                  acc_last,
    output logic                  acc_partial,
    output logic [ACC_W-1:0]      complete_data
);

    logic [CNT_W-1:0] slot_idx;
    logic [ACC_W-1:0] acc_next;

    assign acc_last    = (acc_cnt == CNT_W'(PACK_RATIO - 1));
    assign acc_partial = (acc_cnt != '0);
    assign slot_idx    = SLOT_LSB_FIRST ? acc_cnt : (CNT_W'(PACK_RATIO - 1) - acc_cnt);

    // Accumulator contents with the incoming word placed in its slot.
    always_comb begin
        acc_next = acc_data;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (slot_idx == CNT_W'(i)) begin
                acc_next[i*DATA_WIDTH +: DATA_WIDTH] = push_data;
            end
        end
    end

    // On the final slot the caller takes the whole word, so it is exposed here.
    assign complete_data = acc_next;

    // Slot write and fill count; a completed word or a flush empties the accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_data <= '0;
            acc_cnt  <= '0;
        end else if (push) begin
            if (acc_last) begin
                acc_data <= '0;
                acc_cnt  <= '0;
            end else begin
                acc_data <= acc_next;
                acc_cnt  <= acc_cnt + 1'b1;
            end
        end else if (clear) begin
            acc_data <= '0;
            acc_cnt  <= '0;
        end
    end

endmodule

// File: rtl/fifo_read_packer.sv
// rtl/fifo_read_packer.sv - drains a show-ahead FIFO and packs words onto a valid/ready stream
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_RATIO = 4,
    localparam int WCW       = word_cnt_width(PACK_RATIO),
    localparam int CNT_W     = $clog2(PACK_RATIO),
    localparam int ACC_W     = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  rd_clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [WCW-1:0]        out_words,
    output logic                  busy
);

    generate
        if (PACK_RATIO < 2) begin : g_bad_ratio
            $error("fifo_read_packer: PACK_RATIO must be 2 or greater");
        end
    endgenerate

    logic             flush_pending;
    logic             out_free;
    logic             pop_complete;
    logic             flush_emit;
    logic [ACC_W-1:0] acc_data;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_last;
    logic             acc_partial;
    logic [ACC_W-1:0] complete_data;

    assign out_free = !out_valid || out_ready;

    // Pop unless a flush is draining, or the word would complete with nowhere to go.
    assign fifo_rd_en   = reset_n && !fifo_empty && !flush_pending && (!acc_last || out_free);
    assign pop_complete = fifo_rd_en && acc_last;

    // Flush is held off the pop path, so the two never compete for the accumulator.
    assign flush_emit = flush_pending && acc_partial && out_free;

    assign busy = acc_partial || out_valid || flush_pending;

    pack_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_RATIO (PACK_RATIO)
    ) u_acc (
        .clk           (rd_clk),
        .reset_n       (reset_n),
        .push          (fifo_rd_en),
        .push_data     (fifo_rd_data),
        .clear         (flush_emit),
        .acc_data      (acc_data),
        .acc_cnt       (acc_cnt),
        .acc_last      (acc_last),
        .acc_partial   (acc_partial),
        .complete_data (complete_data)
    );

    // Output register: loads a full or flushed partial word, drops valid after transfer.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_words <= '0;
        end else if (pop_complete) begin
            out_valid <= 1'b1;
            out_data  <= complete_data;
            out_words <= WCW'(PACK_RATIO);
        end else if (flush_emit) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_words <= WCW'(acc_cnt);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flush request latch; repeat requests while pending are absorbed.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_pending <= 1'b0;
        end else if (flush_pending) begin
            if (!acc_partial || out_free) begin
                flush_pending <= 1'b0;
            end
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// tb/tb_fifo_read_packer.sv - scoreboard bench for fifo_read_packer
module tb_fifo_read_packer;

    localparam int DW = 16;
    localparam int PR = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  words;
    } exp_t;

    logic          rd_clk;
    logic          reset_n;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [2:0]    out_words;
    logic          busy;

    fifo_read_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .rd_clk       (rd_clk),
        .reset_n      (reset_n),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_words    (out_words),
        .busy         (busy)
    );

    int          n_compared = 0;
    int          n_mismatch = 0;
    int          pop_cnt    = 0;
    int          hs_cnt     = 0;
    logic        empty_gate = 1'b0;
    logic [DW-1:0] fifo_q[$];
    exp_t        sb[$];

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty   = (fifo_q.size() == 0) || empty_gate;
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic expect_word(input logic [63:0] d, input logic [2:0] w);
        exp_t e;
        e.data  = d;
        e.words = w;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #2;
        end
    endtask

    task automatic wait_pops(input int target, input string name);
        int cyc = 0;
        while (pop_cnt < target && cyc < 100) begin
            tick(1);
            cyc++;
        end
        check({name, "_pop_timeout"}, 64'(pop_cnt >= target), 64'd1);
    endtask

    task automatic wait_sb(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            tick(1);
            cyc++;
        end
        check({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    // FIFO model: pop on the DUT's strobe, present the new head after the edge.
    always @(posedge rd_clk) begin
        if (fifo_empty) check("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
        if (fifo_rd_en && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        #1 refresh();
    end

    // Monitor: every transfer is compared against the head of the scoreboard.
    always @(negedge rd_clk) begin
        if (reset_n && out_valid && out_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL unexpected_output: got data 0x%0h words %0d, none expected", out_data, out_words);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_words", 64'(out_words), 64'(e.words));
            end
        end
    end

    initial begin
        logic [63:0] held;
        int          cyc;
        int          hs_before;
        logic [15:0] vals[$];

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        refresh();
        tick(2);

        // Reset state, with words already waiting
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        tick(1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_words", 64'(out_words), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);

        // Streaming, back-to-back pops
        expect_word(64'h0004_0003_0002_0001, 3'd4);
        expect_word(64'h0008_0007_0006_0005, 3'd4);
        pop_cnt = 0;
        reset_n = 1'b1;
        cyc = 0;
        while (pop_cnt < 4 && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("stream_4th_pop_cycle", 64'(cyc), 64'd4);
        check("stream_valid_after_4th", 64'(out_valid), 64'd1);
        wait_sb("stream");
        check("stream_pops", 64'(pop_cnt), 64'd8);
        tick(2);

        // Backpressure
        out_ready = 1'b0;
        pop_cnt   = 0;
        for (int i = 1; i <= 12; i++) push_word(16'(16'h0100 + i));
        expect_word(pack4(16'h0101, 16'h0102, 16'h0103, 16'h0104), 3'd4);
        expect_word(pack4(16'h0105, 16'h0106, 16'h0107, 16'h0108), 3'd4);
        expect_word(pack4(16'h0109, 16'h010A, 16'h010B, 16'h010C), 3'd4);
        tick(15);
        check("bp_pop_count", 64'(pop_cnt), 64'd7);
        check("bp_rd_en_stalled", 64'(fifo_rd_en), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        held = out_data;
        check("bp_data", held, pack4(16'h0101, 16'h0102, 16'h0103, 16'h0104));
        tick(3);
        check("bp_data_stable", out_data, held);
        check("bp_words_stable", 64'(out_words), 64'd4);
        out_ready = 1'b1;
        wait_sb("bp");
        check("bp_total_pops", 64'(pop_cnt), 64'd12);
        tick(2);

        // Partial flush
        pop_cnt = 0;
        push_word(16'hAAAA);
        push_word(16'hBBBB);
        wait_pops(2, "pflush");
        check("pflush_busy_partial", 64'(busy), 64'd1);
        expect_word(64'h0000_0000_BBBB_AAAA, 3'd2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_sb("pflush");
        tick(2);
        check("pflush_busy_idle", 64'(busy), 64'd0);

        // Flush with an empty accumulator
        hs_before = hs_cnt;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(4);
        check("flush_empty_no_output", 64'(hs_cnt), 64'(hs_before));
        check("flush_empty_busy", 64'(busy), 64'd0);

        // Flush coinciding with the completing pop
        pop_cnt = 0;
        for (int i = 1; i <= 3; i++) push_word(16'(16'h0200 + i));
        wait_pops(3, "fsame");
        hs_before = hs_cnt;
        expect_word(pack4(16'h0201, 16'h0202, 16'h0203, 16'h0204), 3'd4);
        push_word(16'h0204);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("fsame_pop_same_edge", 64'(pop_cnt), 64'd4);
        tick(6);
        check("fsame_one_output", 64'(hs_cnt), 64'(hs_before + 1));
        check("fsame_busy", 64'(busy), 64'd0);
        wait_sb("fsame");

        // Asynchronous reset with a partial accumulator and a held output
        out_ready = 1'b0;
        pop_cnt   = 0;
        for (int i = 1; i <= 6; i++) push_word(16'(16'h0300 + i));
        wait_pops(6, "rmid");
        tick(1);
        check("rmid_valid_before", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rmid_valid", 64'(out_valid), 64'd0);
        check("rmid_words", 64'(out_words), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        tick(2);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        expect_word(pack4(16'h0401, 16'h0402, 16'h0403, 16'h0404), 3'd4);
        for (int i = 1; i <= 4; i++) push_word(16'(16'h0400 + i));
        wait_sb("rmid");
        tick(2);

        // Random empty gaps and random backpressure over 100 words
        for (int i = 0; i < 100; i++) vals.push_back(16'($urandom));
        for (int w = 0; w < 25; w++)
            expect_word(pack4(vals[4*w], vals[4*w+1], vals[4*w+2], vals[4*w+3]), 3'd4);
        for (int i = 0; i < 100; i++) push_word(vals[i]);
        cyc = 0;
        while (sb.size() != 0 && cyc < 3000) begin
            empty_gate = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            refresh();
            tick(1);
            cyc++;
        end
        empty_gate = 1'b0;
        out_ready  = 1'b1;
        refresh();
        check("rand_drain_timeout", 64'(sb.size()), 64'd0);
        tick(4);
        check("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
